// File: rtl/decode_stage.sv
// decode_stage: RV32I instruction decode into a single-entry registered control bundle.
// Latency: 1 cycle from an accepted in_valid/in_instr to out_valid with the decoded bundle.
// Backpressure: in_ready = !out_valid | out_ready; the bundle holds stable while out_ready=0.
//
// Optional feature macro: DECODE_RV32M_EN -- when defined, R-type funct7=0000001 (RV32M)
// decodes to alu_ctrl {3'b100,funct3}; when undefined those encodings are illegal.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           fetch handshake; in_pc, in_instr carry the offered instruction
//   flush                       drops the held bundle and blocks acceptance this cycle
//   out_valid/out_ready         execute handshake
//   out_pc, rs1, rs2, rd,       registered decode bundle; unused register fields and
//   funct3, imm, alu_ctrl,      funct3 (U/J) read 0, imm is sign-extended to XLEN
//   op_a_sel, op_b_sel,         op_a_sel: 00 rs1, 01 PC, 10 PC+4, 11 zero; op_b_sel: 0 rs2, 1 imm
//   branch_op, jump, mem_wen, mem_ren, wb_sel, wen, illegal   control flags
module decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [31:0]     in_instr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [XLEN-1:0] imm,
  output logic [5:0]      alu_ctrl,
  output logic [1:0]      op_a_sel,
  output logic            op_b_sel,
  output logic            branch_op,
  output logic            jump,
  output logic            mem_wen,
  output logic            mem_ren,
  output logic            wb_sel,
  output logic            wen,
  output logic            illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [5:0] ALU_ADD  = 6'b000000;
  localparam logic [5:0] ALU_JAL  = 6'b011111;
  localparam logic [5:0] ALU_JALR = 6'b111111;

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    logic [5:0]      alu_ctrl;
    logic [1:0]      op_a_sel;
    logic            op_b_sel;
    logic            branch_op;
    logic            jump;
    logic            mem_wen;
    logic            mem_ren;
    logic            wb_sel;
    logic            wen;
    logic            illegal;
  } dec_t;

  dec_t            dec_d;
  dec_t            dec_q;
  logic            legal;
  logic            accept;
  logic [6:0]      opcode;
  logic [6:0]      f7;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];

  // Every format sign-extends from instruction bit 31.
  assign imm_i = {{(XLEN-11){in_instr[31]}}, in_instr[30:20]};
  assign imm_s = {{(XLEN-11){in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
  assign imm_b = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_j = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign imm_u = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};

  always_comb begin
    dec_d = '0;
    legal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_d.rs1    = in_instr[19:15];
        dec_d.rs2    = in_instr[24:20];
        dec_d.rd     = in_instr[11:7];
        dec_d.funct3 = f3;
        dec_d.wen    = 1'b1;
        case (f7)
          7'b0000000: begin
            legal          = 1'b1;
            dec_d.alu_ctrl = {3'b000, f3};
          end
          7'b0100000: begin
            // Only sub (000) and sra (101) have an alternate encoding.
            legal          = (f3 == 3'b000) || (f3 == 3'b101);
            dec_d.alu_ctrl = {3'b001, f3};
          end
`ifdef DECODE_RV32M_EN
          7'b0000001: begin
            legal          = 1'b1;
            dec_d.alu_ctrl = {3'b100, f3};
          end
`endif
          default: legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        dec_d.rs1      = in_instr[19:15];
        dec_d.rd       = in_instr[11:7];
        dec_d.funct3   = f3;
        dec_d.imm      = imm_i;
        dec_d.op_b_sel = 1'b1;
        dec_d.wen      = 1'b1;
        dec_d.alu_ctrl = {3'b000, f3};
        // Shift-immediates carry funct7 in imm[11:5]; addi has no sub form.
        if (f3 == 3'b001) begin
          legal = (f7 == 7'b0000000);
        end else if (f3 == 3'b101) begin
          legal          = (f7 == 7'b0000000) || (f7 == 7'b0100000);
          dec_d.alu_ctrl = {2'b00, f7[5], f3};
        end else begin
          legal = 1'b1;
        end
      end
      OPC_LOAD: begin
        legal          = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                         (f3 == 3'b100) || (f3 == 3'b101);
        dec_d.rs1      = in_instr[19:15];
        dec_d.rd       = in_instr[11:7];
        dec_d.funct3   = f3;
        dec_d.imm      = imm_i;
        dec_d.alu_ctrl = ALU_ADD;
        dec_d.op_b_sel = 1'b1;
        dec_d.mem_ren  = 1'b1;
        dec_d.wb_sel   = 1'b1;
        dec_d.wen      = 1'b1;
      end
      OPC_STORE: begin
        legal          = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        dec_d.rs1      = in_instr[19:15];
        dec_d.rs2      = in_instr[24:20];
        dec_d.funct3   = f3;
        dec_d.imm      = imm_s;
        dec_d.alu_ctrl = ALU_ADD;
        dec_d.op_b_sel = 1'b1;
        dec_d.mem_wen  = 1'b1;
      end
      OPC_BRANCH: begin
        legal           = (f3 != 3'b010) && (f3 != 3'b011);
        dec_d.rs1       = in_instr[19:15];
        dec_d.rs2       = in_instr[24:20];
        dec_d.funct3    = f3;
        dec_d.imm       = imm_b;
        dec_d.alu_ctrl  = {3'b010, f3};
        dec_d.branch_op = 1'b1;
      end
      OPC_JAL: begin
        legal          = 1'b1;
        dec_d.rd       = in_instr[11:7];
        dec_d.imm      = imm_j;
        dec_d.alu_ctrl = ALU_JAL;
        dec_d.op_a_sel = 2'b10;
        dec_d.jump     = 1'b1;
        dec_d.wen      = 1'b1;
      end
      OPC_JALR: begin
        legal          = (f3 == 3'b000);
        dec_d.rs1      = in_instr[19:15];
        dec_d.rd       = in_instr[11:7];
        dec_d.funct3   = f3;
        dec_d.imm      = imm_i;
        dec_d.alu_ctrl = ALU_JALR;
        dec_d.op_a_sel = 2'b10;
        dec_d.op_b_sel = 1'b1;
        dec_d.jump     = 1'b1;
        dec_d.wen      = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        legal          = 1'b1;
        dec_d.rd       = in_instr[11:7];
        dec_d.imm      = imm_u;
        dec_d.alu_ctrl = ALU_ADD;
        dec_d.op_a_sel = (opcode == OPC_LUI) ? 2'b11 : 2'b01;
        dec_d.op_b_sel = 1'b1;
        dec_d.wen      = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    // An illegal bundle carries no side effects; only the flag survives.
    if (!legal) begin
      dec_d         = '0;
      dec_d.illegal = 1'b1;
    end
    if (dec_d.rd == 5'd0) begin
      dec_d.wen = 1'b0;
    end
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      dec_q     <= '0;
    end else begin
      // flush wins over a simultaneous accept.
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        out_pc <= in_pc;
        dec_q  <= dec_d;
      end
    end
  end

  assign rs1       = dec_q.rs1;
  assign rs2       = dec_q.rs2;
  assign rd        = dec_q.rd;
  assign funct3    = dec_q.funct3;
  assign imm       = dec_q.imm;
  assign alu_ctrl  = dec_q.alu_ctrl;
  assign op_a_sel  = dec_q.op_a_sel;
  assign op_b_sel  = dec_q.op_b_sel;
  assign branch_op = dec_q.branch_op;
  assign jump      = dec_q.jump;
  assign mem_wen   = dec_q.mem_wen;
  assign mem_ren   = dec_q.mem_ren;
  assign wb_sel    = dec_q.wb_sel;
  assign wen       = dec_q.wen;
  assign illegal   = dec_q.illegal;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath and immediate width (32 or 64).
REQ-002 Parameter PC_W, default 16, program-counter width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  fetch offers instr/pc this cycle.
REQ-006 in_ready  output  1  stage accepts offered instruction.
REQ-007 in_pc  input  PC_W  PC of offered instruction.
REQ-008 in_instr  input  32  raw RV32 instruction word.
REQ-009 flush  input  1  discard held instruction (branch/jump redirect).
REQ-010 out_valid  output  1  decoded bundle valid.
REQ-011 out_ready  input  1  execute consumes bundle.
REQ-012 out_pc  output  PC_W  registered PC.
REQ-013 rs1, rs2, rd  output  5 each  register indices; 0 when unused by format.
REQ-014 funct3  output  3  registered funct3; 0 for U/J formats.
REQ-015 imm  output  XLEN  format-selected immediate, sign-extended to XLEN.
REQ-016 alu_ctrl  output  6  ALU operation code.
REQ-017 op_a_sel  output  2  00 rs1, 01 PC, 10 PC+4, 11 zero.
REQ-018 op_b_sel  output  1  0 rs2, 1 imm.
REQ-019 branch_op, jump, mem_wen, mem_ren, wb_sel, wen, illegal  output  1 each  control flags.

Function
REQ-020 in_ready SHALL equal !out_valid | out_ready (single-entry pipeline register; full throughput when out_ready=1).
REQ-021 On in_valid & in_ready & !flush, all outputs SHALL register the decode of in_instr and out_valid SHALL be 1 the next cycle (latency 1).
REQ-022 On out_valid & out_ready with no new accept, out_valid SHALL clear next cycle.
REQ-023 While out_valid & !out_ready, all outputs SHALL hold stable.
REQ-024 flush SHALL clear out_valid next cycle and block acceptance that cycle; flush beats simultaneous accept.
REQ-025 Immediates: I={i[31:20]}, S={i[31:25],i[11:7]}, B={i[31],i[7],i[30:25],i[11:8],0}, J={i[31],i[19:12],i[20],i[30:21],0}, U={i[31:12],12'b0}; all sign-extended from bit 31.
REQ-026 alu_ctrl codes: add 000000, sub 001000, sll 000001, slt 000010, sltu 000011, xor 000100, srl 000101, sra 001101, or 000110, and 000111; sub/sra selected by i[30] (I-type: sra only).
REQ-027 Branch codes: beq 010000, bne 010001, blt 010100, bge 010101, bltu 010110, bgeu 010111; branch_op=1, wen=0.
REQ-028 JAL: alu_ctrl 011111, jump=1, op_a_sel=10, wen=1; JALR: alu_ctrl 111111, jump=1, op_a_sel=10, wen=1.
REQ-029 LOAD: mem_ren=1, wb_sel=1, op_b_sel=1, alu add; STORE: mem_wen=1, wen=0, op_b_sel=1, alu add.
REQ-030 AUIPC: op_a_sel=01, op_b_sel=1, alu add; LUI: op_a_sel=11, op_b_sel=1, alu add.
REQ-031 wen SHALL be forced 0 when rd==0.
REQ-032 Unrecognised opcode/funct encodings SHALL set illegal=1 with wen=mem_wen=mem_ren=branch_op=jump=0, out_valid still asserted.

Reset
REQ-033 On rst_n=0, out_valid and every output register SHALL clear to 0 immediately, independent of clk; in_ready SHALL read 1.
REQ-034 Reset mid-stall SHALL discard the held bundle; first accept after release decodes normally.

Configuration
REQ-035 Macro DECODE_RV32M_EN: when defined, R-type funct7=0000001 SHALL decode to alu_ctrl {3'b100,funct3}, wen=1; when undefined, such encodings SHALL be illegal per REQ-032.

Verification
REQ-036 0xFFF00093 (addi x1,x0,-1) -> next cycle imm=0xFFFFFFFF, rd=1, rs1=0, alu_ctrl=000000, op_b_sel=1, wen=1.
REQ-037 0xFE208CE3 (beq x1,x2,-8) -> imm=0xFFFFFFF8, rs1=1, rs2=2, alu_ctrl=010000, branch_op=1, wen=0.
REQ-038 0x12345037 (lui x0) -> imm=0x12345000, op_a_sel=11, wen=0.
REQ-039 out_ready=0 with two back-to-back in_valid -> first bundle held stable, in_ready=0; out_ready=1 -> second follows one cycle later.
REQ-040 flush=1 with in_valid=1 and out_valid=1 -> out_valid=0 next cycle, instruction not accepted.
REQ-041 0x022081B3 (mul x3,x1,x2) -> with DECODE_RV32M_EN alu_ctrl=100000, wen=1; without, illegal=1, wen=0.
